dmem_bank: RTL and testbench

Parametrised data-memory bank for the single-cycle/pipelined core's load/store path, successor to the fixed 4 KiB word-only data memory. Adds byte/halfword/word accesses with sign/zero extension, a valid/ready request handshake with registered one-cycle read latency, alignment and range error reporting, and a hardware clear sequence after reset. A parametrised window of words is mirrored onto memory-mapped output channels (board digit drivers).

---
 rtl/dmem_pkg.sv | 54 +++++
 rtl/dmem_ram.sv | 58 +++++
 rtl/dmem_bank.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory bank.
//   size_e        : access size encoding carried on req_size
//   state_e       : bank controller states (clear sequence / normal traffic)
//   load_extend   : picks the addressed byte/half out of a read word and
//                   sign- or zero-extends it to 32 bits
//   store_strobe  : byte-lane write strobes for a store of a given size
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Halfword loads only ever reach lane 0 or 2, so lane[1] alone selects
    // the half; byte loads shift the addressed lane down to bit 0.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input size_e       size,
                                                input logic        is_unsigned);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    return is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_W:    return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] lane,
                                                input size_e      size);
        case (size)
            SZ_B:    return 4'b0001 << lane;
            SZ_H:    return 4'b0011 << lane;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// ---------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, DEPTH_WORDS x 32, with byte write strobes.
// Reads are registered and write-first: a cycle that writes returns the
// post-write word on o_rdata the next cycle.
//   clk          : clock
//   i_en         : port enable (read, and write where strobes are set)
//   i_strobe     : per-byte write strobes
//   i_idx        : word index
//   i_wdata      : write data, already lane-replicated by the caller
//   o_rdata      : registered read data
//   o_mergedLow  : low MIRROR_W bits of the word as it will be after this
//                  cycle's write, for mirror registers that update on the
//                  same edge as the RAM
// ---------------------------------------------------------------------------
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int MIRROR_W    = 4
) (
    input  logic                           clk,
    input  logic                           i_en,
    input  logic [3:0]                     i_strobe,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata,
    output logic [MIRROR_W-1:0]            o_mergedLow
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;
    logic [31:0] w_merged;

    // Build the post-write word: strobed lanes take new data, the rest keep
    // the stored bytes. The same word feeds both the array and the read
    // register, which is what makes the port write-first.
    always_comb begin
        w_merged = r_mem[i_idx];
        for (int b = 0; b < 4; b++) begin
            if (i_strobe[b]) begin
                w_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
            end
        end
    end

    // Array update and registered read on every enabled cycle.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (|i_strobe) begin
                r_mem[i_idx] <= w_merged;
            end
            r_rdata <= w_merged;
        end
    end

    assign o_rdata     = r_rdata;
    assign o_mergedLow = w_merged[MIRROR_W-1:0];

endmodule

// File: rtl/dmem_bank.sv
// ---------------------------------------------------------------------------
// dmem_bank
// Data-memory bank for the core's load/store path. Byte/half/word accesses
// with sign/zero extension, one-cycle registered responses, alignment and
// range error reporting, a clear sequence after reset, and a window of words
// mirrored onto output channels.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_we, req_size      : store/load and access size
//   req_unsigned          : zero-extend loads when set
//   addr, wdata           : byte address and right-aligned store data
//   rsp_valid, rsp_err    : one-cycle response pulse and reject flag
//   rdata                 : extended load data (0 for stores and errors)
//   init_busy             : clear sequence in progress
//   io_out                : mirrored channels, IO_WIDTH bits each
// ---------------------------------------------------------------------------
module dmem_bank
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          IO_CHANNELS = 4,
    parameter int          IO_WIDTH    = 4,
    parameter int          IO_BASE_IDX = DEPTH_WORDS - 9
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [1:0]                      req_size,
    input  logic                            req_unsigned,
    input  logic [31:0]                     addr,
    input  logic [31:0]                     wdata,
    output logic                            rsp_valid,
    output logic                            rsp_err,
    output logic [31:0]                     rdata,
    output logic                            init_busy,
    output logic [IO_CHANNELS*IO_WIDTH-1:0] io_out
);

    localparam int                IDXW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0]       SPAN    = 32'(4 * DEPTH_WORDS);
    localparam logic [IDXW-1:0]   LAST    = IDXW'(DEPTH_WORDS - 1);
    localparam logic [IDXW-1:0]   IO_BASE = IDXW'(IO_BASE_IDX);

    state_e             r_state;
    logic [IDXW-1:0]    r_cnt;
    logic               r_rspValid;
    logic               r_rspErr;
    logic               r_rspLoad;
    logic [1:0]         r_lane;
    size_e              r_size;
    logic               r_unsigned;
    logic [IO_WIDTH-1:0] r_shadow [IO_CHANNELS];

    logic [31:0]        w_offset;
    logic [IDXW-1:0]    w_idx;
    logic [1:0]         w_lane;
    size_e              w_size;
    logic               w_err;
    logic               w_accept;
    logic               w_doStore;
    logic [31:0]        w_storeData;
    logic [IDXW-1:0]    w_chan;
    logic               w_ioHit;
    logic               w_ramEn;
    logic [3:0]         w_ramStrobe;
    logic [IDXW-1:0]    w_ramIdx;
    logic [31:0]        w_ramWdata;
    logic [31:0]        w_ramQ;
    logic [IO_WIDTH-1:0] w_mergedLow;

    // Address decode. An address below BASE_ADDR wraps the subtraction to a
    // huge offset, so one unsigned compare against the span covers both
    // ends of the range. BASE_ADDR is word aligned, so the offset's low
    // bits are the byte lane.
    assign w_offset = addr - BASE_ADDR;
    assign w_idx    = w_offset[IDXW+1:2];
    assign w_lane   = w_offset[1:0];
    assign w_size   = size_e'(req_size);

    assign w_err = (w_offset >= SPAN)
                 | (w_size == SZ_BAD)
                 | ((w_size == SZ_H) & w_lane[0])
                 | ((w_size == SZ_W) & (w_lane != 2'b00));

    assign req_ready = (r_state == ST_RUN);
    assign init_busy = (r_state == ST_INIT);
    assign w_accept  = req_valid & req_ready;
    assign w_doStore = w_accept & req_we & ~w_err;

    // Store data is replicated across lanes so the strobes alone pick
    // where it lands.
    always_comb begin
        w_storeData = wdata;
        case (w_size)
            SZ_B:    w_storeData = {4{wdata[7:0]}};
            SZ_H:    w_storeData = {2{wdata[15:0]}};
            default: w_storeData = wdata;
        endcase
    end

    // The clear sequence and request traffic share the single RAM port.
    // Rejected requests leave the port idle so nothing is read or written.
    always_comb begin
        w_ramEn     = 1'b0;
        w_ramStrobe = 4'b0000;
        w_ramIdx    = w_idx;
        w_ramWdata  = w_storeData;
        if (r_state == ST_INIT) begin
            w_ramEn     = 1'b1;
            w_ramStrobe = 4'b1111;
            w_ramIdx    = r_cnt;
            w_ramWdata  = 32'h0;
        end else begin
            w_ramEn     = w_accept & ~w_err;
            w_ramStrobe = w_doStore ? store_strobe(w_lane, w_size) : 4'b0000;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .MIRROR_W    (IO_WIDTH)
    ) u_ram (
        .clk         (clk),
        .i_en        (w_ramEn),
        .i_strobe    (w_ramStrobe),
        .i_idx       (w_ramIdx),
        .i_wdata     (w_ramWdata),
        .o_rdata     (w_ramQ),
        .o_mergedLow (w_mergedLow)
    );

    // Controller: walk the clear counter over every word, then hand the
    // port to request traffic. The counter wraps back to 0 on the last
    // clear write, ready for the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + IDXW'(1);
            if (r_cnt == LAST) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Response registers. The load's lane/size/sign are kept so the
    // extension can be applied to the RAM's registered read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspLoad  <= 1'b0;
            r_lane     <= 2'b00;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
        end else begin
            r_rspValid <= w_accept;
            r_rspErr   <= w_accept & w_err;
            r_rspLoad  <= w_accept & ~w_err & ~req_we;
            r_lane     <= w_lane;
            r_size     <= w_size;
            r_unsigned <= req_unsigned;
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_err   = r_rspErr;
    assign rdata     = r_rspLoad ? load_extend(w_ramQ, r_lane, r_size, r_unsigned)
                                 : 32'h0;

    // Mirror window hit: the subtraction only yields a channel number when
    // the index is at or above the window base.
    assign w_chan  = w_idx - IO_BASE;
    assign w_ioHit = w_doStore & (w_idx >= IO_BASE) & (w_chan < IDXW'(IO_CHANNELS));

    // Shadows take the merged post-write word on the same edge as the RAM
    // write, and are held clear while the memory is being cleared.
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_INIT)) begin
            for (int k = 0; k < IO_CHANNELS; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_ioHit) begin
            for (int k = 0; k < IO_CHANNELS; k++) begin
                if (w_chan == IDXW'(k)) begin
                    r_shadow[k] <= w_mergedLow;
                end
            end
        end
    end

    for (genvar g = 0; g < IO_CHANNELS; g++) begin : g_io
        assign io_out[g*IO_WIDTH +: IO_WIDTH] = r_shadow[g];
    end

endmodule

// File: tb/tb_dmem_bank.sv
// ---------------------------------------------------------------------------
// tb_dmem_bank
// Directed bench for dmem_bank with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_dmem_bank;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rdata;
    logic        init_busy;
    logic [15:0] io_out;

    int checks;
    int errors;

    dmem_bank dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rdata        (rdata),
        .init_busy    (init_busy),
        .io_out       (io_out)
    );

    // 10 ns clock; stimulus changes and sampling happen on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for exactly one rising edge. Called at a falling
    // edge; returns at the next falling edge, where that request's response
    // is visible. Consecutive calls keep req_valid high on every edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] a,
                                 input logic [31:0] d);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        addr         = a;
        wdata        = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Wait for the clear sequence, counting falling edges with init_busy
    // high, starting at the edge where reset is released.
    task automatic waitClear(output int n);
        n = 0;
        while (init_busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (init_busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_init_busy: got %b expected 1", init_busy); end
        checks++; if (io_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_io_out: got %h expected 0000", io_out); end
        reset = 1'b0;
        waitClear(n);
        checks++; if (n !== 1024) begin errors++; $display("[TB] FAIL clear_length: got %0d cycles expected 1024", n); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_ready: got %b expected 1", req_ready); end
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL clear_load_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL clear_load_err: got %b expected 0", rsp_err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL clear_load_data: got %h expected 00000000", rdata); end
    endtask

    task automatic test_round_trip();
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEADBEEF);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rdata !== 32'h0)
            begin errors++; $display("[TB] FAIL store_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0", rsp_valid, rsp_err, rdata); end
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h1005, 32'h0000007F);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0);
        checks++; if (rdata !== 32'hDEAD7FEF) begin errors++; $display("[TB] FAIL load_word: got %h expected DEAD7FEF", rdata); end
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h1006, 32'h0);
        checks++; if (rdata !== 32'hFFFFDEAD) begin errors++; $display("[TB] FAIL load_half_signed: got %h expected FFFFDEAD", rdata); end
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h1007, 32'h0);
        checks++; if (rdata !== 32'h000000DE) begin errors++; $display("[TB] FAIL load_byte_unsigned: got %h expected 000000DE", rdata); end
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h1004, 32'h0);
        checks++; if (rdata !== 32'hFFFFFFEF) begin errors++; $display("[TB] FAIL load_byte_signed: got %h expected FFFFFFEF", rdata); end
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h1004, 32'h0);
        checks++; if (rdata !== 32'h00007FEF) begin errors++; $display("[TB] FAIL load_half_unsigned: got %h expected 00007FEF", rdata); end
        // Last legal word of the window.
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1FFC, 32'hCAFEF00D);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0);
        checks++; if (rsp_err !== 1'b0 || rdata !== 32'hCAFEF00D)
            begin errors++; $display("[TB] FAIL last_word: got e=%b d=%h expected e=0 d=CAFEF00D", rsp_err, rdata); end
    endtask

    task automatic test_errors();
        logic        eWe   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0]  eSize [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
        logic [31:0] eAddr [5] = '{32'h1002, 32'h1001, 32'h1004, 32'h0FFC, 32'h2000};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(eWe[i], eSize[i], 1'b0, eAddr[i], 32'h12345678);
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rdata !== 32'h0)
                begin errors++; $display("[TB] FAIL error_case%0d: got v=%b e=%b d=%h expected v=1 e=1 d=0", i, rsp_valid, rsp_err, rdata); end
        end
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0);
        checks++; if (rdata !== 32'hDEAD7FEF) begin errors++; $display("[TB] FAIL error_mem_1004: got %h expected DEAD7FEF", rdata); end
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL error_mem_1000: got %h expected 00000000", rdata); end
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0);
        checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL error_mem_1FFC: got %h expected CAFEF00D", rdata); end
    endtask

    task automatic test_io_mirror();
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1FDC, 32'h0000000A);
        checks++; if (io_out !== 16'h000A) begin errors++; $display("[TB] FAIL io_ch0: got %h expected 000A", io_out); end
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1FE8, 32'h00000005);
        checks++; if (io_out !== 16'h500A) begin errors++; $display("[TB] FAIL io_ch3: got %h expected 500A", io_out); end
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h1FE1, 32'h000000FF);
        checks++; if (io_out !== 16'h500A) begin errors++; $display("[TB] FAIL io_byte_upper: got %h expected 500A", io_out); end
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1FE0, 32'hFFFFFFF3);
        checks++; if (io_out !== 16'h503A) begin errors++; $display("[TB] FAIL io_ch1_word: got %h expected 503A", io_out); end
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1FDD, 32'h0000000F);
        checks++; if (rsp_err !== 1'b1 || io_out !== 16'h503A)
            begin errors++; $display("[TB] FAIL io_rejected: got e=%b io=%h expected e=1 io=503A", rsp_err, io_out); end
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1FEC, 32'h0000000F);
        checks++; if (io_out !== 16'h503A) begin errors++; $display("[TB] FAIL io_outside: got %h expected 503A", io_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 20; i++) begin
            a = 32'h1100 + 32'(4 * (i / 2));
            d = 32'h01020304 * 32'(i / 2 + 1);
            applyStimulus((i % 2) == 0, 2'd2, 1'b0, a, d);
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0)
                begin errors++; $display("[TB] FAIL b2b_valid%0d: got v=%b e=%b expected v=1 e=0", i, rsp_valid, rsp_err); end
            if ((i % 2) == 1) begin
                checks++; if (rdata !== d) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, rdata, d); end
            end
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 0", rsp_valid); end
    endtask

    // The load is presented on the same rising edge that samples reset, so
    // its response would have appeared right after that edge.
    task automatic test_reset_mid();
        int n;
        int pulses;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; addr = 32'h1100;
        reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_rsp: got %b expected 0", rsp_valid); end
        checks++; if (init_busy !== 1'b1 || req_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL mid_busy: got busy=%b ready=%b expected 1/0", init_busy, req_ready); end
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        n      = 0;
        while (init_busy && n < 3000) begin
            if (rsp_valid) pulses++;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 1024 || pulses !== 0)
            begin errors++; $display("[TB] FAIL mid_clear: got %0d cycles %0d pulses expected 1024/0", n, pulses); end
        checks++; if (io_out !== 16'h0) begin errors++; $display("[TB] FAIL mid_io_out: got %h expected 0000", io_out); end
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1100, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_mem_1100: got %h expected 00000000", rdata); end
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_mem_1004: got %h expected 00000000", rdata); end
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1FDC, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_mem_1FDC: got %h expected 00000000", rdata); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        addr         = 32'h0;
        wdata        = 32'h0;
        repeat (3) @(negedge clk);
        $display("[TB] reset and clear");
        test_reset();
        $display("[TB] store/load round trip");
        test_round_trip();
        $display("[TB] error responses");
        test_errors();
        $display("[TB] io mirroring");
        test_io_mirror();
        $display("[TB] back-to-back traffic");
        test_back_to_back();
        $display("[TB] reset mid-operation");
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
